// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the clock divider bank.
//   MIN_DIV   : smallest usable divide ratio; requests below it saturate here.
//   CNT_W_DEF : default divide-ratio / counter width.
//   CNT_W_MAX : widest supported ratio; sizes the configuration record.
//   ch_cfg_t  : one channel's configuration {div, en}.
package clk_div_pkg;

  localparam int MIN_DIV   = 2;
  localparam int CNT_W_DEF = 16;
  localparam int CNT_W_MAX = 24;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] div;
    logic                 en;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel (period counter, pending config, output flops).
//   clk_24m : sole clock, rising edge.
//   rstn    : asynchronous active-low reset.
//   wr_i    : configuration write addressed to this channel.
//   div_i   : requested divide ratio.
//   en_i    : requested enable.
//   sync_i  : phase-alignment request (ignored while stopped).
//   clk_o   : registered divided clock.
//   tick_o  : registered one-cycle pulse in the cycle clk_o rises.
//   pend_o  : a written configuration waits for the period boundary.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int   CNT_W   = CNT_W_DEF,
  parameter int   RST_DIV = 2,
  parameter logic RST_EN  = 1'b0
) (
  input  logic             clk_24m,
  input  logic             rstn,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  function automatic logic [CNT_W_MAX-1:0] sat_div(input logic [CNT_W-1:0] v);
    if (v < CNT_W'(MIN_DIV)) return CNT_W_MAX'(MIN_DIV);
    return CNT_W_MAX'(v);
  endfunction

  localparam ch_cfg_t RST_CFG = '{div: sat_div(CNT_W'(RST_DIV)), en: RST_EN};

  ch_cfg_t          cur_q, cur_d;   // active configuration
  ch_cfg_t          pnd_q, pnd_d;   // configuration waiting for the boundary
  logic             pend_q, pend_d;
  logic             run_q, run_d;   // channel currently producing periods
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  ch_cfg_t          new_cfg;
  logic             wrap;

  always_comb begin
    cur_d   = cur_q;
    pnd_d   = pnd_q;
    pend_d  = pend_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    new_cfg = '{div: sat_div(div_i), en: en_i};
    wrap    = (CNT_W_MAX'(cnt_q) == cur_q.div - CNT_W_MAX'(1));

    if (wr_i && (!run_q || sync_i)) begin
      // Stopped channel, or write coinciding with sync: start a fresh period now.
      cur_d  = new_cfg;
      run_d  = en_i;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (!run_q) begin
      // Enabled out of reset but not yet started: first edge begins period 0.
      if (cur_q.en) begin
        run_d = 1'b1;
        cnt_d = '0;
      end
    end else if (sync_i || wrap) begin
      // Period boundary: a write landing on it takes effect directly,
      // otherwise any pending configuration is committed.
      cnt_d  = '0;
      pend_d = 1'b0;
      if (wr_i) begin
        cur_d = new_cfg;
        run_d = en_i;
      end else if (pend_q) begin
        cur_d = pnd_q;
        run_d = pnd_q.en;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (wr_i) begin
        pnd_d  = new_cfg;
        pend_d = 1'b1;
      end
    end

    // Outputs are decoded from next state so they line up with cnt_q.
    clk_d  = run_d && (CNT_W_MAX'(cnt_d) < (cur_d.div >> 1));
    tick_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk_24m or negedge rstn) begin
    if (!rstn) begin
      cur_q  <= RST_CFG;
      pnd_q  <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      pnd_q  <= pnd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent integer clock dividers on clk_24m.
//   clk_24m  : sole clock, rising edge.
//   rstn     : asynchronous active-low reset.
//   cfg_wr   : single-cycle configuration write strobe.
//   cfg_ch   : channel addressed by cfg_wr.
//   cfg_div  : requested divide ratio (0 and 1 run as 2).
//   cfg_en   : requested channel enable.
//   sync_req : realign all running channels to period start.
//   clk_out  : registered divided clock per channel (data, never a flop clock).
//   tick     : per-channel clock enable, high in the cycle clk_out rises.
//   cfg_pend : per-channel configuration waiting for the period boundary.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int   N_CH    = 4,
  parameter int   CNT_W   = CNT_W_DEF,
  parameter int   RST_DIV = 2,
  parameter logic RST_EN  = 1'b0,
  localparam int  CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_24m,
  input  logic            rstn,
  input  logic            cfg_wr,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic            cfg_en,
  input  logic            sync_req,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] cfg_pend
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV),
      .RST_EN  (RST_EN)
    ) u_ch (
      .clk_24m (clk_24m),
      .rstn    (rstn),
      .wr_i    (wr_sel),
      .div_i   (cfg_div),
      .en_i    (cfg_en),
      .sync_i  (sync_req),
      .clk_o   (clk_out[i]),
      .tick_o  (tick[i]),
      .pend_o  (cfg_pend[i])
    );
  end

endmodule
